// File: rtl/status_transmitter.sv
`default_nettype none
// ============================================================================
//  Module   : status_transmitter
//  Purpose  : Serialises a WIDTH-bit status word MSB first towards an MBED
//             controller with a four-phase data_ready / data_ack handshake.
//             data_ack is synchronised into the clk domain and every
//             handshake wait is guarded by a timeout that aborts the word.
//  Revision : 1.0 - initial release
// ============================================================================
module status_transmitter #(
   parameter int WIDTH          = 10,
   parameter int SETUP_CYCLES   = 4,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] tx_word,
   input  logic             tx_load,
   input  logic             data_ack,
   output logic             data_ready,
   output logic             data_bit,
   output logic             tx_busy,
   output logic             tx_done,
   output logic             tx_error,
   output logic [2:0]       tx_state
);

   // Counter widths. Each counter only has to reach its "last" value, so
   // log2 of the count is enough; the guards keep degenerate sizes legal.
   localparam int BC_W = (WIDTH > 1)          ? $clog2(WIDTH)          : 1;
   localparam int SC_W = (SETUP_CYCLES > 1)   ? $clog2(SETUP_CYCLES)   : 1;
   localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [BC_W-1:0] C_BIT_LAST   = BC_W'(WIDTH - 1);
   localparam logic [SC_W-1:0] C_SETUP_LAST = SC_W'(SETUP_CYCLES - 1);
   localparam logic [TO_W-1:0] C_TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

   // Encodings are visible on tx_state, so they are fixed explicitly.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_STROBE  = 3'd2,
      ST_RELEASE = 3'd3,
      ST_DONE    = 3'd4,
      ST_ABORT   = 3'd5
   } state_t;

   state_t            state_q,     state_d;
   logic [WIDTH-1:0]  shift_q,     shift_d;
   logic [BC_W-1:0]   bit_cnt_q,   bit_cnt_d;
   logic [SC_W-1:0]   setup_cnt_q, setup_cnt_d;
   logic [TO_W-1:0]   to_cnt_q,    to_cnt_d;
   logic              data_ready_q, data_ready_d;
   logic              ack_meta_q;
   logic              ack_s_q;
   logic              to_run;
   logic              state_change;

   // Two-flop synchroniser: data_ack comes from another clock domain and
   // only the second flop is ever looked at by the control logic.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ack_meta_q <= 1'b0;
         ack_s_q    <= 1'b0;
      end else begin
         ack_meta_q <= data_ack;
         ack_s_q    <= ack_meta_q;
      end
   end

   // Timeout runs while waiting on an ack edge: in SETUP only while the
   // previous ack is still stuck high, and throughout STROBE and RELEASE.
   always_comb begin
      to_run = 1'b0;
      case (state_q)
         ST_SETUP:   to_run = ack_s_q;
         ST_STROBE:  to_run = 1'b1;
         ST_RELEASE: to_run = 1'b1;
         default:    to_run = 1'b0;
      endcase
   end

   // Next-state logic, shift register and bit counter updates.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (tx_load) begin
               shift_d   = tx_word;
               bit_cnt_d = '0;
               state_d   = ST_SETUP;
            end
         end
         ST_SETUP: begin
            // Leave only after the full setup window and with ack released;
            // a stuck-high ack can therefore only end in ABORT or recovery.
            if ((setup_cnt_q == C_SETUP_LAST) && !ack_s_q) begin
               state_d = ST_STROBE;
            end else if (ack_s_q && (to_cnt_q == C_TO_LAST)) begin
               state_d = ST_ABORT;
            end
         end
         ST_STROBE: begin
            if (ack_s_q) begin
               state_d = ST_RELEASE;
            end else if (to_cnt_q == C_TO_LAST) begin
               state_d = ST_ABORT;
            end
         end
         ST_RELEASE: begin
            if (!ack_s_q) begin
               if (bit_cnt_q == C_BIT_LAST) begin
                  state_d = ST_DONE;
               end else begin
                  // data_bit moves here, together with SETUP entry, so the
                  // setup window always precedes the next data_ready rise.
                  shift_d   = {shift_q[WIDTH-2:0], 1'b0};
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  state_d   = ST_SETUP;
               end
            end else if (to_cnt_q == C_TO_LAST) begin
               state_d = ST_ABORT;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         ST_ABORT: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Setup and timeout counters restart on every state entry.
   always_comb begin
      state_change = (state_d != state_q);
      setup_cnt_d  = setup_cnt_q;
      to_cnt_d     = to_cnt_q;
      if (state_change) begin
         setup_cnt_d = '0;
         to_cnt_d    = '0;
      end else begin
         // Setup count saturates so a long ack-stuck wait cannot wrap it.
         if ((state_q == ST_SETUP) && (setup_cnt_q != C_SETUP_LAST)) begin
            setup_cnt_d = setup_cnt_q + 1'b1;
         end
         if (to_run) begin
            to_cnt_d = to_cnt_q + 1'b1;
         end
      end
      // Registered from the next state so the strobe is glitch-free and
      // aligned exactly with the STROBE state.
      data_ready_d = (state_d == ST_STROBE);
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         setup_cnt_q  <= '0;
         to_cnt_q     <= '0;
         data_ready_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         setup_cnt_q  <= setup_cnt_d;
         to_cnt_q     <= to_cnt_d;
         data_ready_q <= data_ready_d;
      end
   end

   // Status outputs decode the registered state; DONE and ABORT are
   // distinct one-cycle states, so tx_done and tx_error are exclusive.
   assign data_ready = data_ready_q;
   assign data_bit   = shift_q[WIDTH-1];
   assign tx_busy    = (state_q != ST_IDLE);
   assign tx_done    = (state_q == ST_DONE);
   assign tx_error   = (state_q == ST_ABORT);
   assign tx_state   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_status_transmitter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_status_transmitter
//  Purpose  : Directed bench for status_transmitter with an MBED responder
//             and a bit scoreboard filled at load time.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_status_transmitter;

   localparam int W = 10;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [W-1:0]  tx_word = '0;
   logic          tx_load = 1'b0;
   logic          data_ack;
   logic          data_ready;
   logic          data_bit;
   logic          tx_busy;
   logic          tx_done;
   logic          tx_error;
   logic [2:0]    tx_state;

   int            checks = 0;
   int            errors = 0;
   bit            exp_q[$];
   int            bits_seen = 0;
   int            done_cnt = 0;
   int            err_cnt = 0;
   logic          prev_ready = 1'b0;
   logic          prev_bit = 1'b0;
   bit            exp_bit;

   logic          force_en = 1'b0;
   logic          force_val = 1'b0;
   logic          mbed_ack = 1'b0;
   logic [2:0]    hist = 3'b000;

   status_transmitter #(
      .WIDTH          (W),
      .SETUP_CYCLES   (4),
      .TIMEOUT_CYCLES (50)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .tx_word    (tx_word),
      .tx_load    (tx_load),
      .data_ack   (data_ack),
      .data_ready (data_ready),
      .data_bit   (data_bit),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .tx_error   (tx_error),
      .tx_state   (tx_state)
   );

   always #5 clk = ~clk;

   assign data_ack = force_en ? force_val : mbed_ack;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // MBED responder: ack 3 clocks after data_ready rises, drop 3 after it falls.
   always @(posedge clk) begin
      if (!reset) begin
         hist     <= 3'b000;
         mbed_ack <= 1'b0;
      end else begin
         hist <= {hist[1:0], data_ready};
         if ({hist[1:0], data_ready} == 3'b111) mbed_ack <= 1'b1;
         else if ({hist[1:0], data_ready} == 3'b000) mbed_ack <= 1'b0;
      end
   end

   // Monitor: capture a bit on every data_ready rise and score it.
   always @(negedge clk) begin
      if (tx_done)  done_cnt++;
      if (tx_error) err_cnt++;
      if (tx_done || tx_error) check("done_err_exclusive", 32'(tx_done & tx_error), 32'd0);
      if (data_ready && !prev_ready) begin
         bits_seen++;
         check("bit_stable_at_rise", 32'(data_bit), 32'(prev_bit));
         check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            exp_bit = exp_q.pop_front();
            check("data_bit", 32'(data_bit), 32'(exp_bit));
         end
      end
      prev_ready = data_ready;
      prev_bit   = data_bit;
   end

   task automatic push_word(input logic [W-1:0] w);
      for (int i = W-1; i >= 0; i--) exp_q.push_back(w[i]);
   endtask

   task automatic load_word(input logic [W-1:0] w);
      @(negedge clk);
      tx_word = w;
      tx_load = 1'b1;
      push_word(w);
      @(negedge clk);
      tx_load = 1'b0;
      check("load_busy",  32'(tx_busy),  32'd1);
      check("load_state", 32'(tx_state), 32'd1);
      check("load_msb",   32'(data_bit), 32'(w[W-1]));
   endtask

   task automatic wait_done(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (tx_done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_bits(input int target, input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (bits_seen >= target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      bit ok;
      int base_done, base_err, base_bits, hi, bad_rdy, bad_st;

      // ---------------- reset state ----------------
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(data_ready), 32'd0);
      check("rst_bit",   32'(data_bit),   32'd0);
      check("rst_busy",  32'(tx_busy),    32'd0);
      check("rst_done",  32'(tx_done),    32'd0);
      check("rst_error", 32'(tx_error),   32'd0);
      check("rst_state", 32'(tx_state),   32'd0);
      reset = 1'b1;
      repeat (3) @(negedge clk);

      // ---------------- nominal word ----------------
      base_done = done_cnt;
      load_word(10'b1100000101);
      wait_done(1000, ok);
      check("nom_done_seen", 32'(ok), 32'd1);
      check("nom_busy_in_done", 32'(tx_busy), 32'd1);
      @(negedge clk);
      check("nom_busy_after", 32'(tx_busy),  32'd0);
      check("nom_idle_after", 32'(tx_state), 32'd0);
      check("nom_done_count", 32'(done_cnt - base_done), 32'd1);
      check("nom_sb_empty",   32'(exp_q.size()), 32'd0);

      // ---------------- load while busy ----------------
      base_done = done_cnt;
      base_bits = bits_seen;
      load_word(10'b1001101001);
      wait_bits(base_bits + 4, 500, ok);
      check("busy_reach_bit4", 32'(ok), 32'd1);
      tx_word = 10'h3FF;
      tx_load = 1'b1;
      @(negedge clk);
      tx_load = 1'b0;
      check("busy_still_busy", 32'(tx_busy), 32'd1);
      wait_done(1000, ok);
      check("busy_done_seen", 32'(ok), 32'd1);
      @(negedge clk);
      @(negedge clk);
      check("busy_done_count", 32'(done_cnt - base_done), 32'd1);
      check("busy_sb_empty",   32'(exp_q.size()), 32'd0);
      check("busy_idle",       32'(tx_state), 32'd0);

      // ---------------- timeout with ack held low ----------------
      base_done = done_cnt;
      base_err  = err_cnt;
      force_val = 1'b0;
      force_en  = 1'b1;
      load_word(10'b1011001110);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (data_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("to_ready_rose", 32'(ok), 32'd1);
      hi = 0;
      while (data_ready && hi < 200) begin
         hi++;
         @(negedge clk);
      end
      check("to_ready_cycles", 32'(hi), 32'd50);
      check("to_error_pulse",  32'(tx_error), 32'd1);
      check("to_abort_state",  32'(tx_state), 32'd5);
      check("to_no_done",      32'(tx_done),  32'd0);
      @(negedge clk);
      check("to_idle",       32'(tx_state), 32'd0);
      check("to_error_once", 32'(tx_error), 32'd0);
      @(negedge clk);
      check("to_err_count",  32'(err_cnt - base_err),   32'd1);
      check("to_done_count", 32'(done_cnt - base_done), 32'd0);
      check("to_sb_left",    32'(exp_q.size()), 32'd9);
      exp_q.delete();
      force_en = 1'b0;
      repeat (4) @(negedge clk);

      // ---------------- ack stuck high at load ----------------
      base_done = done_cnt;
      base_err  = err_cnt;
      force_val = 1'b1;
      force_en  = 1'b1;
      repeat (4) @(negedge clk);
      load_word(10'b0111010010);
      bad_rdy = 0;
      bad_st  = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (data_ready) bad_rdy++;
         if (tx_state != 3'd1) bad_st++;
      end
      check("stuck_ready_low",  32'(bad_rdy), 32'd0);
      check("stuck_in_setup",   32'(bad_st),  32'd0);
      force_en = 1'b0;
      wait_done(1000, ok);
      check("stuck_done_seen", 32'(ok), 32'd1);
      @(negedge clk);
      @(negedge clk);
      check("stuck_done_count", 32'(done_cnt - base_done), 32'd1);
      check("stuck_no_error",   32'(err_cnt - base_err),   32'd0);
      check("stuck_sb_empty",   32'(exp_q.size()), 32'd0);

      // ---------------- reset mid-word ----------------
      base_done = done_cnt;
      base_err  = err_cnt;
      base_bits = bits_seen;
      load_word(10'b0110110010);
      wait_bits(base_bits + 3, 500, ok);
      check("rstmid_reach_bit3", 32'(ok), 32'd1);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (tx_state == 3'd3) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("rstmid_release", 32'(ok), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("rstmid_ready", 32'(data_ready), 32'd0);
      check("rstmid_busy",  32'(tx_busy),    32'd0);
      check("rstmid_state", 32'(tx_state),   32'd0);
      repeat (30) @(negedge clk);
      check("rstmid_no_done",  32'(done_cnt - base_done), 32'd0);
      check("rstmid_no_error", 32'(err_cnt - base_err),   32'd0);
      check("rstmid_stay_idle", 32'(tx_state), 32'd0);
      exp_q.delete();

      // ---------------- back-to-back with load held ----------------
      base_done = done_cnt;
      @(negedge clk);
      tx_word = 10'h155;
      tx_load = 1'b1;
      push_word(10'h155);
      wait_done(1000, ok);
      check("b2b_first_done", 32'(ok), 32'd1);
      push_word(10'h155);
      @(negedge clk);
      check("b2b_idle_after_done", 32'(tx_state), 32'd0);
      @(negedge clk);
      check("b2b_reaccept", 32'(tx_state), 32'd1);
      check("b2b_msb", 32'(data_bit), 32'd0);
      wait_done(1000, ok);
      check("b2b_second_done", 32'(ok), 32'd1);
      tx_load = 1'b0;
      repeat (3) @(negedge clk);
      check("b2b_done_count", 32'(done_cnt - base_done), 32'd2);
      check("b2b_sb_empty",   32'(exp_q.size()), 32'd0);
      check("b2b_final_idle", 32'(tx_state), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/status_transmitter.md
STATUS_TRANSMITTER -- requirements
Module: status_transmitter

Interface
REQ-001 Parameter: WIDTH, 10, status word length in bits.
REQ-002 Parameter: SETUP_CYCLES, 4, clocks data_bit is held stable before data_ready rises.
REQ-003 Parameter: TIMEOUT_CYCLES, 1000000, max clocks waiting on any single data_ack edge (20 ms at 50 MHz).
REQ-004 Port: clk  in  1  sole clock, rising-edge.
REQ-005 Port: reset  in  1  synchronous, active-low; all state returns to IDLE when sampled 0.
REQ-006 Port: tx_word  in  WIDTH  status word to send; sampled only on an accepted tx_load.
REQ-007 Port: tx_load  in  1  send request; accepted only in IDLE.
REQ-008 Port: data_ack  in  1  MBED acknowledge, asynchronous to clk.
REQ-009 Port: data_ready  out  1  strobe to MBED; high = data_bit valid.
REQ-010 Port: data_bit  out  1  serial data line.
REQ-011 Port: tx_busy  out  1  high from accepted load until return to IDLE.
REQ-012 Port: tx_done  out  1  one-cycle pulse on successful completion.
REQ-013 Port: tx_error  out  1  one-cycle pulse on timeout abort.
REQ-014 Port: tx_state  out  3  debug: current state encoding (IDLE=0, SETUP=1, STROBE=2, RELEASE=3, DONE=4, ABORT=5).

Function
REQ-015 data_ack passes through a 2-flop synchronizer; only its output (ack_s) is used; ack changes reach the FSM 2 clocks after the input.
REQ-016 IDLE: data_ready=0, tx_busy=0; tx_load=1 at edge N loads tx_word into the shift register, clears the bit counter, enters SETUP; tx_busy=1 and data_bit=tx_word[WIDTH-1] from N+1.
REQ-017 Bits go MSB first; data_bit always equals the current shift-register MSB and changes only on SETUP entry.
REQ-018 SETUP: data_ready=0; exits to STROBE once SETUP_CYCLES clocks have elapsed in SETUP and ack_s=0; if ack_s stays 1, the timeout counter runs.
REQ-019 STROBE: data_ready=1; on ack_s=1 enters RELEASE.
REQ-020 RELEASE: data_ready=0; on ack_s=0, if bit counter = WIDTH-1 enters DONE, else shifts left one bit, increments the counter, and enters SETUP.
REQ-021 DONE lasts exactly one cycle: tx_done=1, tx_busy=1; next state IDLE.
REQ-022 Timeout counter clears on every state entry and counts while in SETUP (ack_s=1 only), STROBE, or RELEASE; reaching TIMEOUT_CYCLES enters ABORT.
REQ-023 ABORT lasts one cycle: data_ready=0, tx_error=1, tx_busy=1; next state IDLE; tx_done not asserted for the word.
REQ-024 tx_load while not in IDLE is ignored and not queued; tx_load in the same cycle DONE or ABORT returns to IDLE is ignored.
REQ-025 data_ready is registered, has no glitches, and never rises in the same cycle data_bit changes.
REQ-026 tx_done and tx_error are never high together.

Reset
REQ-027 While reset=0 at an edge: state=IDLE, data_ready=0, data_bit=0, tx_busy=0, tx_done=0, tx_error=0, tx_state=0, counters and shift register=0, synchronizer flops=0.
REQ-028 Reset mid-word aborts silently: no tx_done, no tx_error; data_ready=0 from the next cycle.

Verification
REQ-029 Nominal: tx_word=10'b1100000101, MBED model acks 3 clocks after data_ready rises and drops ack 3 clocks after data_ready falls -> captured bits 1,1,0,0,0,0,0,1,0,1, exactly one tx_done pulse, tx_busy low the cycle after.
REQ-030 Timeout: TIMEOUT_CYCLES=50, data_ack held 0 -> data_ready high for 50 clocks on bit 0, then one tx_error pulse, data_ready=0, IDLE, no tx_done.
REQ-031 Ack stuck high: data_ack=1 at load -> stays in SETUP with data_ready=0; releasing ack after 20 clocks (TIMEOUT_CYCLES=50) -> transfer completes normally.
REQ-032 Reset mid-word: reset=0 for 1 cycle after 3 bits acked -> next cycle data_ready=0, tx_busy=0, tx_state=0; no tx_done or tx_error pulse.
REQ-033 Load while busy: second tx_load=1 with tx_word=10'h3FF during bit 4 -> ignored; first word sent intact; one tx_done.
REQ-034 Back-to-back: tx_load held high continuously with tx_word=10'h155 -> new word accepted the cycle after IDLE is re-entered; two tx_done pulses, two identical bit streams.
